tag_lookup: RTL and testbench
=============================

TAG_LOOKUP -- requirements
Module: tag_lookup

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 25, tag field width.
REQ-002 SHALL have parameter INDEX_WIDTH, default 7, line index width.
REQ-003 SHALL have parameter CACHE_LINES, default 128, number of lines (2**INDEX_WIDTH).
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, equal to TAG_WIDTH+INDEX_WIDTH; addr = {tag, index}.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  input  1  lookup request present.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  lookup address.
REQ-009 SHALL have port req_ready  output  1  request accepted when req_valid&req_ready.
REQ-010 SHALL have port inv  input  1  invalidate all lines.
REQ-011 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port resp_hit  output  1  1=hit, 0=miss; meaningful only with resp_valid.
REQ-013 SHALL have port refill_req  output  1  miss refill request, level.
REQ-014 SHALL have port refill_addr  output  ADDR_WIDTH  address being refilled.
REQ-015 SHALL have port refill_ack  input  1  refill complete, single-cycle pulse.
REQ-016 SHALL have port tag_index  output  INDEX_WIDTH  tag RAM index.
REQ-017 SHALL have port tag_wdata  output  TAG_WIDTH  tag RAM write data.
REQ-018 SHALL have port tag_we  output  1  tag RAM write enable.
REQ-019 SHALL have port tag_rdata  input  TAG_WIDTH  tag RAM read data, valid one cycle after index presented.
REQ-020 SHALL have ports hit_count, miss_count  output  16  statistics counters.

Function
REQ-021 SHALL implement FSM states IDLE, LOOKUP, REFILL, UPDATE.
REQ-022 IDLE: req_ready=!inv; on inv=1, clear all CACHE_LINES valid bits that edge, stay IDLE (inv has priority over req_valid).
REQ-023 IDLE with req_valid&req_ready: latch req_addr, go LOOKUP.
REQ-024 tag_index SHALL be req_addr[INDEX_WIDTH-1:0] combinationally in IDLE, latched index in all other states.
REQ-025 LOOKUP: hit = valid[index] & (tag_rdata == latched tag); on hit assert resp_valid=1, resp_hit=1 this cycle, go IDLE.
REQ-026 LOOKUP miss: go REFILL; no response this cycle.
REQ-027 REFILL: refill_req=1, refill_addr=latched address; hold until refill_ack=1, then go UPDATE; refill_ack outside REFILL ignored.
REQ-028 UPDATE: tag_we=1, tag_wdata=latched tag, set valid[index]; resp_valid=1, resp_hit=0; go IDLE.
REQ-029 Latency: hit response 1 cycle after acceptance; miss response 1 cycle after refill_ack; max one request per 2 cycles.
REQ-030 tag_we SHALL be asserted only in UPDATE; refill_req only in REFILL.
REQ-031 hit_count increments on each hit response, miss_count on each entry to REFILL; both saturate at 16'hFFFF.
REQ-032 inv outside IDLE SHALL be ignored; it takes effect only when sampled in IDLE.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, all valid bits 0, counters 0, latched address 0, resp_valid/resp_hit/refill_req/tag_we 0.
REQ-034 Reset during REFILL SHALL drop refill_req asynchronously and perform no tag write.

Verification
REQ-035 After reset, request addr 0x0000_0085 -> miss; refill_req with refill_addr 0x0000_0085; ack -> tag_we=1, tag_index=0x05, tag_wdata=0x1; resp_hit=0; miss_count=1.
REQ-036 Repeat 0x0000_0085 with tag_rdata=0x1 -> resp_valid, resp_hit=1 one cycle after acceptance; hit_count=1.
REQ-037 Request 0x0000_0105 (same index 0x05, tag 0x2) with tag_rdata=0x1 -> miss, refill, tag overwritten to 0x2.
REQ-038 inv=1 and req_valid=1 together in IDLE -> req_ready=0, valid bits cleared; following request 0x0000_0105 -> miss.
REQ-039 rst_n low while in REFILL waiting on ack -> refill_req=0 at once, no tag_we, IDLE after release.
REQ-040 Force 65536 misses -> miss_count holds 16'hFFFF, no wrap.

Source files
------------

// File: rtl/tag_lookup.sv
// Tag lookup controller for a direct-mapped cache.
// The tag array is an external synchronous-read RAM. This block keeps the
// per-line valid bits, runs the lookup/refill sequence and counts hits and
// misses.
module tag_lookup #(
  parameter int TAG_WIDTH   = 25,
  parameter int INDEX_WIDTH = 7,
  parameter int CACHE_LINES = 128,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  output logic                   req_ready,
  input  logic                   inv,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic                   refill_req,
  output logic [ADDR_WIDTH-1:0]  refill_addr,
  input  logic                   refill_ack,
  output logic [INDEX_WIDTH-1:0] tag_index,
  output logic [TAG_WIDTH-1:0]   tag_wdata,
  output logic                   tag_we,
  input  logic [TAG_WIDTH-1:0]   tag_rdata,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CACHE_LINES-1:0]  valid_q, valid_d;
  logic [15:0]             hit_cnt_q, hit_cnt_d;
  logic [15:0]             miss_cnt_q, miss_cnt_d;

  logic [TAG_WIDTH-1:0]    lat_tag;
  logic [INDEX_WIDTH-1:0]  lat_idx;
  logic                    lookup_hit;

  assign lat_tag = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
  assign lat_idx = addr_q[INDEX_WIDTH-1:0];

  // Tag RAM data arrives in LOOKUP for the index presented during IDLE.
  assign lookup_hit = valid_q[lat_idx] && (tag_rdata == lat_tag);

  // Outputs are decoded from the registered state, so reset clears them at once.
  assign req_ready   = (state_q == IDLE) && !inv;
  assign tag_index   = (state_q == IDLE) ? req_addr[INDEX_WIDTH-1:0] : lat_idx;
  assign resp_hit    = (state_q == LOOKUP) && lookup_hit;
  assign resp_valid  = resp_hit || (state_q == UPDATE);
  assign refill_req  = (state_q == REFILL);
  assign refill_addr = addr_q;
  assign tag_we      = (state_q == UPDATE);
  assign tag_wdata   = lat_tag;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

  // Next-state, valid-bit and saturating-counter update.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: begin
        // Invalidate wins over a pending request; req_ready is low meanwhile.
        if (inv) begin
          valid_d = '0;
        end else if (req_valid) begin
          addr_d  = req_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lookup_hit) begin
          state_d = IDLE;
          if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
        end else begin
          state_d = REFILL;
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
      end
      REFILL: begin
        if (refill_ack) state_d = UPDATE;
      end
      UPDATE: begin
        valid_d[lat_idx] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_tag_lookup.sv
// Directed bench for tag_lookup with a behavioural synchronous tag RAM.
module tb_tag_lookup;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        inv;
  logic        resp_valid;
  logic        resp_hit;
  logic        refill_req;
  logic [31:0] refill_addr;
  logic        refill_ack;
  logic [6:0]  tag_index;
  logic [24:0] tag_wdata;
  logic        tag_we;
  logic [24:0] tag_rdata;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [24:0] ram [128];

  tag_lookup dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .inv(inv),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .refill_req(refill_req), .refill_addr(refill_addr), .refill_ack(refill_ack),
    .tag_index(tag_index), .tag_wdata(tag_wdata), .tag_we(tag_we),
    .tag_rdata(tag_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read tag RAM
  always @(posedge clk) begin
    if (tag_we) ram[tag_index] <= tag_wdata;
    tag_rdata <= ram[tag_index];
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Full miss sequence; inv is pulsed while waiting in REFILL and must be ignored.
  task automatic do_miss(input logic [31:0] a, input logic [15:0] exp_miss);
    req_valid = 1'b1; req_addr = a; #1;
    chk("miss_ready", {31'd0, req_ready}, 32'd1);
    chk("miss_idx_idle", {25'd0, tag_index}, {25'd0, a[6:0]});
    tick; req_valid = 1'b0; req_addr = 32'h0; #1;
    chk("miss_lookup_resp", {31'd0, resp_valid}, 32'd0);
    chk("miss_idx_latched", {25'd0, tag_index}, {25'd0, a[6:0]});
    tick;
    chk("refill_req", {31'd0, refill_req}, 32'd1);
    chk("refill_addr", refill_addr, a);
    chk("miss_count", {16'd0, miss_count}, {16'd0, exp_miss});
    inv = 1'b1;
    tick; inv = 1'b0; #1;
    chk("refill_hold", {31'd0, refill_req}, 32'd1);
    chk("refill_no_we", {31'd0, tag_we}, 32'd0);
    refill_ack = 1'b1;
    tick; refill_ack = 1'b0; #1;
    chk("upd_we", {31'd0, tag_we}, 32'd1);
    chk("upd_idx", {25'd0, tag_index}, {25'd0, a[6:0]});
    chk("upd_wdata", {7'd0, tag_wdata}, {7'd0, a[31:7]});
    chk("upd_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("upd_resp_hit", {31'd0, resp_hit}, 32'd0);
    chk("upd_refill_low", {31'd0, refill_req}, 32'd0);
    tick;
    chk("post_upd_we", {31'd0, tag_we}, 32'd0);
    chk("post_upd_resp", {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic do_hit(input logic [31:0] a, input logic [15:0] exp_hit);
    req_valid = 1'b1; req_addr = a; #1;
    chk("hit_ready", {31'd0, req_ready}, 32'd1);
    tick; req_valid = 1'b0; req_addr = 32'h0; #1;
    chk("hit_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("hit_resp_hit", {31'd0, resp_hit}, 32'd1);
    chk("hit_no_refill", {31'd0, refill_req}, 32'd0);
    tick;
    chk("hit_count", {16'd0, hit_count}, {16'd0, exp_hit});
    chk("hit_back_idle", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; inv = 1'b0; refill_ack = 1'b0;
    tick; tick;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
    chk("rst_refill_req", {31'd0, refill_req}, 32'd0);
    chk("rst_tag_we", {31'd0, tag_we}, 32'd0);
    chk("rst_hit_count", {16'd0, hit_count}, 32'd0);
    chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
    chk("rst_refill_addr", refill_addr, 32'd0);
    rst_n = 1'b1;
    tick;
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // Cold miss, then hit on the same line
    do_miss(32'h0000_0085, 16'd1);
    do_hit(32'h0000_0085, 16'd1);

    // Stray refill_ack in IDLE does nothing
    refill_ack = 1'b1;
    tick; refill_ack = 1'b0; #1;
    chk("stray_ack_refill", {31'd0, refill_req}, 32'd0);
    chk("stray_ack_we", {31'd0, tag_we}, 32'd0);
    chk("stray_ack_resp", {31'd0, resp_valid}, 32'd0);

    // Conflict miss on index 5, tag 2 replaces tag 1; inv inside REFILL ignored
    do_miss(32'h0000_0105, 16'd2);
    do_hit(32'h0000_0105, 16'd2);

    // inv together with req_valid: not accepted, lines cleared
    inv = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_0105; #1;
    chk("inv_ready_low", {31'd0, req_ready}, 32'd0);
    tick; inv = 1'b0; req_valid = 1'b0; #1;
    chk("inv_no_lookup_resp", {31'd0, resp_valid}, 32'd0);
    chk("inv_still_idle", {31'd0, req_ready}, 32'd1);
    tick;
    chk("inv_no_refill", {31'd0, refill_req}, 32'd0);
    do_miss(32'h0000_0105, 16'd3);

    // Reset while waiting in REFILL
    req_valid = 1'b1; req_addr = 32'h0000_0205;
    tick; req_valid = 1'b0; #1;
    tick;
    chk("pre_rst_refill", {31'd0, refill_req}, 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("async_rst_refill", {31'd0, refill_req}, 32'd0);
    chk("async_rst_we", {31'd0, tag_we}, 32'd0);
    chk("async_rst_miss", {16'd0, miss_count}, 32'd0);
    chk("async_rst_hit", {16'd0, hit_count}, 32'd0);
    refill_ack = 1'b1;
    tick; refill_ack = 1'b0; #1;
    chk("rst_hold_we", {31'd0, tag_we}, 32'd0);
    rst_n = 1'b1;
    tick;
    chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_release_we", {31'd0, tag_we}, 32'd0);
    chk("rst_release_refill", {31'd0, refill_req}, 32'd0);
    // Valid bits were cleared by reset
    do_miss(32'h0000_0085, 16'd1);

    // Saturation: preload the miss counter just below the limit
    force dut.miss_cnt_q = 16'hFFFE;
    tick;
    release dut.miss_cnt_q;
    #1;
    chk("preload_miss", {16'd0, miss_count}, 32'h0000_FFFE);
    do_miss(32'h0000_0305, 16'hFFFF);
    do_miss(32'h0000_0405, 16'hFFFF);
    chk("sat_hit_unchanged", {16'd0, hit_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
